// File: rtl/load_ctrl_if.sv
// Button/enable bundle for load_ctrl.
//   btn_ld_a, btn_ld_r : raw bouncing buttons (operand load, result capture)
//   en_a, en_r         : one-cycle register load enables
//   state              : FSM state (EMPTY=0, LOADED=1, DONE=2)
//   err                : one-cycle pulse on a rejected capture request
//   cap_cnt            : count of issued en_r pulses, wraps at 256
interface load_ctrl_if;
  logic       btn_ld_a;
  logic       btn_ld_r;
  logic       en_a;
  logic       en_r;
  logic [1:0] state;
  logic       err;
  logic [7:0] cap_cnt;

  modport master (
    output btn_ld_a, btn_ld_r,
    input  en_a, en_r, state, err, cap_cnt
  );

  modport slave (
    input  btn_ld_a, btn_ld_r,
    output en_a, en_r, state, err, cap_cnt
  );
endinterface

// File: rtl/load_ctrl.sv
// Debounced two-button load controller: synchronizes and debounces the
// operand-load and result-capture buttons, then sequences the operand and
// result register enables through an EMPTY/LOADED/DONE state machine.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : load_ctrl_if.slave (buttons in, enables/state/err/cap_cnt out)
//   DB_CYCLES: stable cycles needed to accept a button change (>= 2)
module load_ctrl #(
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  load_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
  localparam int unsigned N_BTN = 2;
  localparam int unsigned CAP_W = 8;
  localparam int unsigned BTN_A = 0;
  localparam int unsigned BTN_R = 1;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    LOADED = 2'd1,
    DONE   = 2'd2
  } state_t;

  logic [N_BTN-1:0] raw;
  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;
  logic [N_BTN-1:0] db_q;
  logic [N_BTN-1:0] req_q;
  logic [CNT_W-1:0] cnt_q [N_BTN];

  logic req_a;
  logic req_r;

  state_t           state_q, state_d;
  logic             pending_q, pending_d;
  logic             en_a_q, en_a_d;
  logic             en_r_q, en_r_d;
  logic             err_q, err_d;
  logic [CAP_W-1:0] cap_q, cap_d;

  assign raw = {bus.btn_ld_r, bus.btn_ld_a};

  // 2-flop synchronizer, debounce counter and rising-edge request per button.
  // The level flips on the cycle the counter would reach DB_CYCLES, so a
  // clean edge yields its request 2 + DB_CYCLES cycles after it is sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      req_q   <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      req_q   <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_W'(DB_CYCLES - 1)) begin
          cnt_q[i] <= '0;
          db_q[i]  <= ~db_q[i];
          req_q[i] <= ~db_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign req_a = req_q[BTN_A];
  assign req_r = req_q[BTN_R];

  // FSM and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      pending_q <= 1'b0;
      en_a_q    <= 1'b0;
      en_r_q    <= 1'b0;
      err_q     <= 1'b0;
      cap_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      en_a_q    <= en_a_d;
      en_r_q    <= en_r_d;
      err_q     <= err_d;
      cap_q     <= cap_d;
    end
  end

  // Next state / next outputs.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    en_a_d    = 1'b0;
    en_r_d    = 1'b0;
    err_d     = 1'b0;

    if (pending_q) begin
      // Deferred operand load after a simultaneous capture; a fresh req_a
      // folds into it. req_r cannot recur this soon after the previous one.
      en_a_d    = 1'b1;
      state_d   = LOADED;
      pending_d = 1'b0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (req_a) begin
            en_a_d  = 1'b1;
            state_d = LOADED;
          end
          err_d = req_r;
        end
        LOADED, DONE: begin
          if (req_r) begin
            en_r_d    = 1'b1;
            state_d   = DONE;
            pending_d = req_a;
          end else if (req_a) begin
            en_a_d  = 1'b1;
            state_d = LOADED;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    cap_d = cap_q + CAP_W'(en_r_d);
  end

  assign bus.en_a    = en_a_q;
  assign bus.en_r    = en_r_q;
  assign bus.err     = err_q;
  assign bus.state   = state_q;
  assign bus.cap_cnt = cap_q;

endmodule

// File: tb/tb_load_ctrl.sv
// Directed bench for load_ctrl with DB_CYCLES=4 and an expected-pulse queue.
module tb_load_ctrl;

  localparam int unsigned DB  = 4;
  localparam int          LAT = 2 + DB + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int         due;
    logic       en_a;
    logic       en_r;
    logic       err;
    logic [1:0] state;
    logic [7:0] cap;
  } exp_t;

  exp_t exp_q[$];

  load_ctrl_if ifc ();

  load_ctrl #(.DB_CYCLES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push(input int due, input logic ea, input logic er, input logic e,
                      input logic [1:0] st, input logic [7:0] cap);
    exp_t x;
    x.due = due; x.en_a = ea; x.en_r = er; x.err = e; x.state = st; x.cap = cap;
    exp_q.push_back(x);
  endtask

  task automatic check_cycle();
    exp_t e;
    chk("en_exclusive", 32'(ifc.en_a & ifc.en_r), 32'd0);
    chk("state_legal", 32'(ifc.state == 2'd3), 32'd0);
    while (exp_q.size() != 0 && exp_q[0].due < cyc) begin
      e = exp_q.pop_front();
      chk("missed_pulse_cycle", 32'(cyc), 32'(e.due));
    end
    if (ifc.en_a | ifc.en_r | ifc.err) begin
      if (exp_q.size() == 0) begin
        chk("spurious_pulse", {29'd0, ifc.en_a, ifc.en_r, ifc.err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_cycle", 32'(cyc), 32'(e.due));
        chk("en_a", 32'(ifc.en_a), 32'(e.en_a));
        chk("en_r", 32'(ifc.en_r), 32'(e.en_r));
        chk("err", 32'(ifc.err), 32'(e.err));
        chk("state", 32'(ifc.state), 32'(e.state));
        chk("cap_cnt", 32'(ifc.cap_cnt), 32'(e.cap));
      end
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_cycle();
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic drive(input logic a, input logic r);
    ifc.btn_ld_a = a;
    ifc.btn_ld_r = r;
  endtask

  task automatic chk_idle(input string tag, input logic [1:0] st, input logic [7:0] cap);
    chk({tag, "_en_a"}, 32'(ifc.en_a), 32'd0);
    chk({tag, "_en_r"}, 32'(ifc.en_r), 32'd0);
    chk({tag, "_err"}, 32'(ifc.err), 32'd0);
    chk({tag, "_state"}, 32'(ifc.state), 32'(st));
    chk({tag, "_cap"}, 32'(ifc.cap_cnt), 32'(cap));
  endtask

  initial begin
    drive(1'b0, 1'b0);
    #1 rst = 1'b1;
    step(3);
    chk_idle("reset", 2'd0, 8'd0);
    rst = 1'b0;
    step(3);

    // Capture request from EMPTY is rejected.
    drive(1'b0, 1'b1);
    push(cyc + LAT, 1'b0, 1'b0, 1'b1, 2'd0, 8'd0);
    drain(12);
    drive(1'b0, 1'b0);
    step(8);
    chk_idle("after_err", 2'd0, 8'd0);

    // Clean operand press: EMPTY -> LOADED.
    drive(1'b1, 1'b0);
    push(cyc + LAT, 1'b1, 1'b0, 1'b0, 2'd1, 8'd0);
    drain(12);
    step(3);
    drive(1'b0, 1'b0);
    step(8);
    chk_idle("after_load", 2'd1, 8'd0);

    // Bouncing press: one reload counted from the final edge.
    drive(1'b1, 1'b0); step(2);
    drive(1'b0, 1'b0); step(2);
    drive(1'b1, 1'b0); step(2);
    drive(1'b0, 1'b0); step(2);
    drive(1'b1, 1'b0);
    push(cyc + LAT, 1'b1, 1'b0, 1'b0, 2'd1, 8'd0);
    drain(12);
    step(3);
    drive(1'b0, 1'b0);
    step(8);

    // Both buttons together in LOADED: capture first, then deferred load.
    drive(1'b1, 1'b1);
    push(cyc + LAT,     1'b0, 1'b1, 1'b0, 2'd2, 8'd1);
    push(cyc + LAT + 1, 1'b1, 1'b0, 1'b0, 2'd1, 8'd1);
    drain(14);
    step(3);
    drive(1'b0, 1'b0);
    step(8);
    chk_idle("after_both", 2'd1, 8'd1);

    // Reset three cycles into a debounce clears everything at once.
    drive(1'b1, 1'b0);
    step(3);
    rst = 1'b1;
    #1;
    chk_idle("async_rst", 2'd0, 8'd0);
    step(2);
    drive(1'b0, 1'b0);
    step(1);
    rst = 1'b0;
    step(15);
    chk_idle("post_rst", 2'd0, 8'd0);

    // Button held through reset release counts as a fresh press.
    drive(1'b1, 1'b0);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    push(cyc + LAT, 1'b1, 1'b0, 1'b0, 2'd1, 8'd0);
    drain(12);
    step(5);
    drive(1'b0, 1'b0);
    step(8);

    // 256 captures: counter wraps back to 0, state remains DONE.
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 1'b1);
      push(cyc + LAT, 1'b0, 1'b1, 1'b0, 2'd2, 8'(i + 1));
      step(10);
      drive(1'b0, 1'b0);
      step(8);
    end
    drain(4);
    chk_idle("wrap", 2'd2, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
